load_unit: RTL and testbench
============================

// Module: load_unit
// PURPOSE
// - Memory-side responder for the load buffer's issue port: accepts one load per cycle (addr, ROB tag) via valid/ready.
// - Reads word-addressed data BRAM with fixed latency; tracks in-flight tags in a shift pipe.
// - Queues results in a response FIFO for the CDB/ROB writeback arbiter.
// - Credit-based admission: a response slot exists for every accepted load; FIFO never overflows.
// PARAMETERS
// - ROB_IX           2   ROB tag MSB index; tag width ROB_IX+1
// - MEM_LATENCY      2   cycles from mem_en_out to valid mem_data_in (>=1)
// - RESP_FIFO_DEPTH  4   response FIFO entries, power of 2, >= MEM_LATENCY+1
// - MEM_ADDR_W       10  BRAM word-address width
// PORTS
// - clk_in           in   1             clock
// - rst_n_in         in   1             async active-low reset
// - flush_in         in   1             mispredict flush, sync
// - req_valid_in     in   1             load buffer valid_out
// - req_addr_in      in   32            byte address (load buffer dest_out)
// - req_rob_ix_in    in   ROB_IX+1      ROB tag of the load
// - req_ready_out    out  1             to load buffer read_in; accept = req_valid_in & req_ready_out
// - mem_en_out       out  1             BRAM read enable
// - mem_addr_out     out  MEM_ADDR_W    req_addr_in[MEM_ADDR_W+1:2]
// - mem_data_in      in   32            BRAM data, valid MEM_LATENCY cycles after mem_en_out
// - resp_valid_out   out  1             FIFO head valid
// - resp_data_out    out  32            loaded word
// - resp_rob_ix_out  out  ROB_IX+1      tag of loaded word
// - resp_ready_in    in   1             writeback arbiter consumes head
// - resp_misalign_out out 1             only with LOAD_UNIT_MISALIGN_CHECK_EN
// BEHAVIOUR
// - Reset: async on rst_n_in=0; clears in-flight pipe, FIFO ptrs/count, credit counter.
// - Outputs in reset: req_ready_out=0, mem_en_out=0, resp_valid_out=0, resp_data_out=0, resp_rob_ix_out=0.
// - Release: req_ready_out=1 from the first cycle after deassertion.
// - Credits: used = in-flight + FIFO count; req_ready_out = !flush_in && used < RESP_FIFO_DEPTH.
// - req_ready_out registered-state driven only; no combinational dependence on req_valid_in.
// - Accept in cycle N: mem_en_out=1 and mem_addr_out driven in cycle N (combinational).
// - Tag enters pipe stage 0 at end of N and reaches the last stage after MEM_LATENCY cycles.
// - In cycle N+MEM_LATENCY: mem_data_in is sampled with the tag and pushed to the FIFO.
// - resp_valid_out=1 from cycle N+MEM_LATENCY+1; minimum load-to-response latency MEM_LATENCY+1.
// - Order: responses leave in acceptance order; one accept and one pop per cycle max.
// - Pop: resp_valid_out & resp_ready_in pops head. Push and pop in the same cycle leave count unchanged.
// - Full FIFO: unreachable by credit rule. An assertion fires on push while full.
// - Empty FIFO: resp_valid_out=0; outputs hold last head value and are don't-care.
// - Flush: synchronous on flush_in=1.
//   - Clears all pipe valid bits and FIFO (count=0, ptrs=0); req_ready_out=0 that cycle.
//   - BRAM data returning for squashed loads is discarded.
//   - Pop in the flush cycle is ignored; a push in the flush cycle is dropped.
// - mem_en_out=0 whenever no accept occurs.
// - Reset asserted mid-operation: immediate async clear; all in-flight loads lost.
// CONFIGURATION
// - LOAD_UNIT_MISALIGN_CHECK_EN defined: misalignment flagging enabled.
//   - req_addr_in[1:0]!=0 still reads BRAM and follows normal order.
//   - FIFO entry carries misalign=1 and resp_data_out=0; resp_misalign_out reports head flag.
// - Undefined: req_addr_in[1:0] ignored; resp_misalign_out port absent.
// TESTING
// - Single load: addr=0x10, tag=3, BRAM[4]=0xDEADBEEF -> mem_en_out=1, mem_addr_out=4 in cycle N.
//   Response 0xDEADBEEF/tag 3 valid at cycle N+3 (MEM_LATENCY=2).
// - Back-to-back: tags 0,1,2,3 on consecutive cycles, resp_ready_in=1 -> four responses on consecutive cycles in tag order.
// - Backpressure: resp_ready_in=0 with continuous requests -> exactly 4 accepts, then req_ready_out=0.
//   Raising resp_ready_in for 1 cycle reopens exactly 1 credit.
// - Flush: accept 2 loads, flush_in=1 one cycle later -> no response ever appears.
//   req_ready_out=0 in the flush cycle and 1 the next.
// - Async reset mid-flight with 3 FIFO entries -> resp_valid_out=0 without waiting for a clock edge.
//   First request after release returns normally.
// - Misalign (macro on): addr=0x13, tag 5 -> resp_misalign_out=1, data 0.
//   Macro off: BRAM[4] data is returned.

Source files
------------

// File: rtl/load_unit.sv
// Memory-side load responder: fixed-latency BRAM read, in-flight tag pipe, response FIFO with credit admission.
// Optional feature macro: LOAD_UNIT_MISALIGN_CHECK_EN (flags loads whose byte address is not word aligned).
module load_unit #(
    parameter int ROB_IX          = 2,
    parameter int MEM_LATENCY     = 2,
    parameter int RESP_FIFO_DEPTH = 4,
    parameter int MEM_ADDR_W      = 10
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  flush_in,
    input  logic                  req_valid_in,
    input  logic [31:0]           req_addr_in,
    input  logic [ROB_IX:0]       req_rob_ix_in,
    output logic                  req_ready_out,
    output logic                  mem_en_out,
    output logic [MEM_ADDR_W-1:0] mem_addr_out,
    input  logic [31:0]           mem_data_in,
    output logic                  resp_valid_out,
    output logic [31:0]           resp_data_out,
    output logic [ROB_IX:0]       resp_rob_ix_out,
    input  logic                  resp_ready_in
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
    ,
    output logic                  resp_misalign_out
`endif
);

    localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                   alive_q, alive_d;
    logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ROB_IX:0]        pipe_tag_q [MEM_LATENCY];
    logic [ROB_IX:0]        pipe_tag_d [MEM_LATENCY];
    logic [31:0]            fifo_data_q [RESP_FIFO_DEPTH];
    logic [31:0]            fifo_data_d [RESP_FIFO_DEPTH];
    logic [ROB_IX:0]        fifo_tag_q [RESP_FIFO_DEPTH];
    logic [ROB_IX:0]        fifo_tag_d [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       inflight, used;
    logic                   accept, push, pop;
    logic [31:0]            push_data;

`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
    logic [MEM_LATENCY-1:0]     pipe_mis_q, pipe_mis_d;
    logic [RESP_FIFO_DEPTH-1:0] fifo_mis_q, fifo_mis_d;
    logic                       unused_addr_bits;
    assign unused_addr_bits  = ^req_addr_in[31:MEM_ADDR_W+2];
    assign resp_misalign_out = fifo_mis_q[rptr_q];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_in[31:MEM_ADDR_W+2], req_addr_in[1:0]};
`endif

    // Every outstanding load (in the pipe or queued) holds one FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[i]);
        end
        used           = inflight + count_q;
        req_ready_out  = alive_q && !flush_in && (used < CNT_W'(RESP_FIFO_DEPTH));
        accept         = req_valid_in && req_ready_out;
        mem_en_out     = accept;
        mem_addr_out   = req_addr_in[MEM_ADDR_W+1:2];
        resp_valid_out = (count_q != '0);
        resp_data_out  = fifo_data_q[rptr_q];
        resp_rob_ix_out = fifo_tag_q[rptr_q];
        push           = pipe_vld_q[MEM_LATENCY-1] && !flush_in;
        pop            = resp_valid_out && resp_ready_in && !flush_in;
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
        push_data      = pipe_mis_q[MEM_LATENCY-1] ? 32'h0 : mem_data_in;
`else
        push_data      = mem_data_in;
`endif
    end

    always_comb begin
        alive_d       = 1'b1;
        pipe_vld_d    = '0;
        pipe_tag_d    = pipe_tag_q;
        pipe_vld_d[0] = accept;
        pipe_tag_d[0] = req_rob_ix_in;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
        fifo_data_d = fifo_data_q;
        fifo_tag_d  = fifo_tag_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
        pipe_mis_d    = '0;
        pipe_mis_d[0] = (req_addr_in[1:0] != 2'b00);
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_mis_d[i] = pipe_mis_q[i-1];
        end
        fifo_mis_d = fifo_mis_q;
        if (push) begin
            fifo_mis_d[wptr_q] = pipe_mis_q[MEM_LATENCY-1];
        end
`endif
        if (push) begin
            fifo_data_d[wptr_q] = push_data;
            fifo_tag_d[wptr_q]  = pipe_tag_q[MEM_LATENCY-1];
            wptr_d              = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // A flush squashes everything outstanding; late BRAM data for those loads is simply never pushed.
        if (flush_in) begin
            pipe_vld_d = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            alive_q    <= 1'b0;
            pipe_vld_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
            end
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
            pipe_mis_q <= '0;
            fifo_mis_q <= '0;
`endif
        end else begin
            alive_q     <= alive_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_tag_q  <= pipe_tag_d;
            fifo_data_q <= fifo_data_d;
            fifo_tag_q  <= fifo_tag_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
            pipe_mis_q  <= pipe_mis_d;
            fifo_mis_q  <= fifo_mis_d;
`endif
        end
    end

    assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(push && (count_q == CNT_W'(RESP_FIFO_DEPTH))));

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_load_unit;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk_in;
    logic        rst_n_in;
    logic        flush_in;
    logic        req_valid_in;
    logic [31:0] req_addr_in;
    logic [2:0]  req_rob_ix_in;
    logic        req_ready_out;
    logic        mem_en_out;
    logic [9:0]  mem_addr_out;
    logic [31:0] mem_data_in;
    logic        resp_valid_out;
    logic [31:0] resp_data_out;
    logic [2:0]  resp_rob_ix_out;
    logic        resp_ready_in;
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
    logic        resp_misalign_out;
`endif

    load_unit #(
        .ROB_IX(2), .MEM_LATENCY(LAT), .RESP_FIFO_DEPTH(DEPTH), .MEM_ADDR_W(10)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .flush_in(flush_in),
        .req_valid_in(req_valid_in),
        .req_addr_in(req_addr_in),
        .req_rob_ix_in(req_rob_ix_in),
        .req_ready_out(req_ready_out),
        .mem_en_out(mem_en_out),
        .mem_addr_out(mem_addr_out),
        .mem_data_in(mem_data_in),
        .resp_valid_out(resp_valid_out),
        .resp_data_out(resp_data_out),
        .resp_rob_ix_out(resp_rob_ix_out),
        .resp_ready_in(resp_ready_in)
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
        ,
        .resp_misalign_out(resp_misalign_out)
`endif
    );

    typedef struct {
        logic [2:0]  tag;
        logic [31:0] data;
        logic        mis;
        int          readyCycle;
    } resp_t;

    resp_t       expQ[$];
    logic [31:0] bram [1024];
    logic [31:0] rdStage;
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          acceptCount = 0;
    logic        alive = 1'b0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // BRAM model: data for an enable in cycle N is presented during cycle N+2.
    always @(posedge clk_in) begin
        rdStage     <= mem_en_out ? bram[mem_addr_out] : $urandom;
        mem_data_in <= rdStage;
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check after settling, update the model at the posedge.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [2:0] t,
                                 input logic r, input logic f);
        logic  expReady, accept, expValid, pop, mis;
        resp_t e;
        req_valid_in  = v;
        req_addr_in   = a;
        req_rob_ix_in = t;
        resp_ready_in = r;
        flush_in      = f;
        #1;
        expReady = alive && !f && (expQ.size() < DEPTH);
        checkOutput("req_ready", req_ready_out, expReady);
        accept = v && expReady;
        checkOutput("mem_en", mem_en_out, accept);
        if (accept) checkOutput("mem_addr", mem_addr_out, a[11:2]);
        expValid = (expQ.size() > 0) && (expQ[0].readyCycle <= cycle);
        checkOutput("resp_valid", resp_valid_out, expValid);
        if (expValid) begin
            checkOutput("resp_data", resp_data_out, expQ[0].data);
            checkOutput("resp_tag", resp_rob_ix_out, expQ[0].tag);
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
            checkOutput("resp_misalign", resp_misalign_out, expQ[0].mis);
`endif
        end
        pop = expValid && r && !f;
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        @(posedge clk_in);
        if (f) begin
            expQ.delete();
        end else begin
            if (pop) void'(expQ.pop_front());
            if (accept) begin
                e.tag        = t;
                e.data       = mis ? 32'h0 : bram[a[11:2]];
                e.mis        = mis;
                e.readyCycle = cycle + LAT + 1;
                expQ.push_back(e);
            end
        end
        if (accept) acceptCount++;
        cycle++;
        @(negedge clk_in);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 3'd0, r, 1'b0);
    endtask

    task automatic releaseReset();
        req_valid_in = 1'b0;
        rst_n_in     = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        alive = 1'b1;
    endtask

    initial begin
        int startCount;
        for (int i = 0; i < 1024; i++) bram[i] = $urandom;
        bram[4]       = 32'hDEADBEEF;
        rst_n_in      = 1'b0;
        flush_in      = 1'b0;
        req_valid_in  = 1'b1;
        req_addr_in   = 32'h10;
        req_rob_ix_in = 3'd1;
        resp_ready_in = 1'b1;

        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("rst_ready", req_ready_out, 1'b0);
        checkOutput("rst_mem_en", mem_en_out, 1'b0);
        checkOutput("rst_resp_valid", resp_valid_out, 1'b0);
        checkOutput("rst_resp_data", resp_data_out, 32'h0);
        checkOutput("rst_resp_tag", resp_rob_ix_out, 3'd0);
        releaseReset();

        $display("[TB] single load");
        applyStimulus(1'b1, 32'h10, 3'd3, 1'b1, 1'b0);
        idle(5, 1'b1);

        $display("[TB] back-to-back");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4 + 32), 3'(i), 1'b1, 1'b0);
        idle(6, 1'b1);

        $display("[TB] backpressure");
        startCount = acceptCount;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'(i * 4), 3'(i), 1'b0, 1'b0);
        checkOutput("bp_accepts", 32'(acceptCount - startCount), 32'd4);
        startCount = acceptCount;
        applyStimulus(1'b1, 32'h40, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h44, 3'd7, 1'b0, 1'b0);
        checkOutput("bp_reopen", 32'(acceptCount - startCount), 32'd1);
        idle(8, 1'b1);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h20, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h24, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h28, 3'd3, 1'b1, 1'b1);
        idle(6, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, 3'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        idle(8, 1'b1);

        $display("[TB] async reset mid-flight");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(i * 4 + 64), 3'(i), 1'b0, 1'b0);
        idle(3, 1'b0);
        checkOutput("pre_rst_valid", resp_valid_out, 1'b1);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("async_rst_valid", resp_valid_out, 1'b0);
        checkOutput("async_rst_ready", req_ready_out, 1'b0);
        checkOutput("async_rst_data", resp_data_out, 32'h0);
        expQ.delete();
        alive = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        releaseReset();
        applyStimulus(1'b1, 32'h10, 3'd4, 1'b1, 1'b0);
        idle(5, 1'b1);

        $display("[TB] misaligned address");
        applyStimulus(1'b1, 32'h13, 3'd5, 1'b1, 1'b0);
        idle(5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
